demux_rr_param: RTL and testbench

Parametrised 1:N demultiplexer with a registered output stage per channel and a valid/ready handshake on every port. Generalises the team's 1-bit, 2-output demux to WIDTH-bit words and CHANNELS outputs. Two run-time steering modes: round-robin, where an internal pointer distributes successive words across channels, and addressed, where a `sel` input picks the channel. Sits between a single producer and N consumer lanes; per-channel backpressure is honoured without losing or duplicating words.

---
 rtl/demux_rr_param.sv | 88 ++++++++
 tb/tb_demux_rr_param.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/demux_rr_param.sv
// 1:N demultiplexer with a registered valid/ready stage per output channel.
// Words are steered either round-robin by an internal pointer or by an explicit sel.
module demux_rr_param #(
   parameter int WIDTH = 8,
   parameter int CHANNELS = 2,
   localparam int SEL_W = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      reset_L,
   input  logic [WIDTH-1:0]          data_in,
   input  logic                      valid_in,
   output logic                      ready_out,
   input  logic                      mode,
   input  logic [SEL_W-1:0]          sel,
   output logic [CHANNELS*WIDTH-1:0] data_out,
   output logic [CHANNELS-1:0]       valid_out,
   input  logic [CHANNELS-1:0]       ready_in,
   output logic [7:0]                drop_count
);

   localparam int PtrSpan = 1 << SEL_W;
   localparam logic [SEL_W:0]   ChanCount = (SEL_W+1)'(CHANNELS);
   localparam logic [SEL_W-1:0] LastChan  = SEL_W'(CHANNELS - 1);

   logic [CHANNELS*WIDTH-1:0] data_q, data_d;
   logic [CHANNELS-1:0]       valid_q, valid_d;
   logic [SEL_W-1:0]          rrPtr_q, rrPtr_d;
   logic [7:0]                dropCount_q, dropCount_d;

   logic [CHANNELS-1:0] chanFree;
   logic [PtrSpan-1:0]  freeExt;
   logic [SEL_W-1:0]    target;
   logic                dropSel;
   logic                accept;
   logic                writeEn;

   // Out-of-range addresses only exist when CHANNELS is not a power of two;
   // freeExt pads the free vector so indexing by target never runs off the end.
   always_comb begin
      chanFree = ~valid_q | ready_in;
      freeExt = '0;
      freeExt[CHANNELS-1:0] = chanFree;
      target = mode ? sel : rrPtr_q;
      dropSel = mode && !({1'b0, sel} < ChanCount);
      ready_out = dropSel ? 1'b1 : freeExt[target];
      accept = valid_in && ready_out;
      writeEn = accept && !dropSel;
   end

   // A channel drains when its consumer is ready; a same-cycle write wins so valid stays up.
   always_comb begin
      data_d = data_q;
      valid_d = valid_q & ~ready_in;
      rrPtr_d = rrPtr_q;
      dropCount_d = dropCount_q;
      for (int k = 0; k < CHANNELS; k++) begin
         if (writeEn && target == SEL_W'(k)) begin
            data_d[k*WIDTH +: WIDTH] = data_in;
            valid_d[k] = 1'b1;
         end
      end
      if (writeEn && !mode) begin
         rrPtr_d = (rrPtr_q == LastChan) ? '0 : rrPtr_q + SEL_W'(1);
      end
      if (accept && dropSel && dropCount_q != 8'hFF) begin
         dropCount_d = dropCount_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         data_q <= '0;
         valid_q <= '0;
         rrPtr_q <= '0;
         dropCount_q <= '0;
      end else begin
         data_q <= data_d;
         valid_q <= valid_d;
         rrPtr_q <= rrPtr_d;
         dropCount_q <= dropCount_d;
      end
   end

   assign data_out = data_q;
   assign valid_out = valid_q;
   assign drop_count = dropCount_q;

endmodule

// File: tb/tb_demux_rr_param.sv
// Directed bench for demux_rr_param: three instances (2, 3 and 4 channels)
// share clock and reset, each exercised by its own section of the sequence.
module tb_demux_rr_param;

   logic clk = 1'b0;
   logic reset_L;
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   // Two-channel instance: backpressure
   logic [7:0]  d2In;
   logic        v2In, r2Out, m2;
   logic [0:0]  s2;
   logic [15:0] d2Out;
   logic [1:0]  v2Out, rdy2;
   logic [7:0]  drop2;

   // Three-channel instance: addressed mode and drop path
   logic [7:0]  d3In;
   logic        v3In, r3Out, m3;
   logic [1:0]  s3;
   logic [23:0] d3Out;
   logic [2:0]  v3Out, rdy3;
   logic [7:0]  drop3;

   // Four-channel instance: reset, round-robin, mode switching
   logic [7:0]  d4In;
   logic        v4In, r4Out, m4;
   logic [1:0]  s4;
   logic [31:0] d4Out;
   logic [3:0]  v4Out, rdy4;
   logic [7:0]  drop4;

   demux_rr_param #(.WIDTH(8), .CHANNELS(2)) u2 (
      .clk(clk), .reset_L(reset_L), .data_in(d2In), .valid_in(v2In),
      .ready_out(r2Out), .mode(m2), .sel(s2), .data_out(d2Out),
      .valid_out(v2Out), .ready_in(rdy2), .drop_count(drop2)
   );

   demux_rr_param #(.WIDTH(8), .CHANNELS(3)) u3 (
      .clk(clk), .reset_L(reset_L), .data_in(d3In), .valid_in(v3In),
      .ready_out(r3Out), .mode(m3), .sel(s3), .data_out(d3Out),
      .valid_out(v3Out), .ready_in(rdy3), .drop_count(drop3)
   );

   demux_rr_param #(.WIDTH(8), .CHANNELS(4)) u4 (
      .clk(clk), .reset_L(reset_L), .data_in(d4In), .valid_in(v4In),
      .ready_out(r4Out), .mode(m4), .sel(s4), .data_out(d4Out),
      .valid_out(v4Out), .ready_in(rdy4), .drop_count(drop4)
   );

   // Advance one rising edge and settle just after it so registered outputs are stable.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset_L = 1'b0;
      d2In = 8'h00; v2In = 1'b0; m2 = 1'b0; s2 = 1'b0; rdy2 = 2'b00;
      d3In = 8'h00; v3In = 1'b0; m3 = 1'b0; s3 = 2'd0; rdy3 = 3'b000;
      d4In = 8'hA5; v4In = 1'b0; m4 = 1'b0; s4 = 2'd0; rdy4 = 4'b0000;

      // Reset state
      #2;
      checkOutput("rst_valid4", 32'(v4Out), 32'h0);
      checkOutput("rst_data4", d4Out, 32'h0);
      checkOutput("rst_drop4", 32'(drop4), 32'h0);
      checkOutput("rst_ready4", 32'(r4Out), 32'h1);
      checkOutput("rst_valid3", 32'(v3Out), 32'h0);
      checkOutput("rst_drop3", 32'(drop3), 32'h0);

      // First word after release lands on channel 0
      @(negedge clk);
      reset_L = 1'b1;
      v4In = 1'b1;
      rdy4 = 4'b1111;
      applyStimulus();
      checkOutput("first_valid", 32'(v4Out), 32'h1);
      checkOutput("first_data", 32'(d4Out[7:0]), 32'hA5);

      // Fill every channel with C3 while holding consumers off (pointer now 1)
      rdy4 = 4'b0000;
      d4In = 8'hC3;
      #1;
      checkOutput("fill_ready", 32'(r4Out), 32'h1);
      for (int i = 0; i < 3; i++) applyStimulus();
      checkOutput("fill_valid", 32'(v4Out), 32'hF);
      checkOutput("stall_ready", 32'(r4Out), 32'h0);
      rdy4 = 4'b0001;
      #1;
      checkOutput("unstall_ready", 32'(r4Out), 32'h1);
      applyStimulus();
      rdy4 = 4'b0000;
      v4In = 1'b0;
      #1;
      checkOutput("full_valid", 32'(v4Out), 32'hF);
      checkOutput("full_data", d4Out, 32'hC3C3C3C3);

      // Asynchronous reset pulse between edges
      reset_L = 1'b0;
      #1;
      checkOutput("async_rst_valid", 32'(v4Out), 32'h0);
      checkOutput("async_rst_data", d4Out, 32'h0);
      reset_L = 1'b1;
      #1;

      // Round-robin across four always-ready consumers
      rdy4 = 4'b1111;
      m4 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         d4In = 8'(i + 1);
         v4In = 1'b1;
         #1;
         checkOutput($sformatf("rr_ready_%0d", i), 32'(r4Out), 32'h1);
         applyStimulus();
         checkOutput($sformatf("rr_valid_%0d", i), 32'(v4Out), 32'(4'b0001 << (i % 4)));
         checkOutput($sformatf("rr_data_%0d", i), 32'(d4Out[(i % 4)*8 +: 8]), 32'(i + 1));
      end
      v4In = 1'b0;
      applyStimulus();
      checkOutput("rr_drained", 32'(v4Out), 32'h0);

      // Mode switch: addressed words must not move the round-robin pointer
      v4In = 1'b1;
      d4In = 8'hAA;
      applyStimulus();
      checkOutput("ms_w0", 32'(v4Out), 32'h1);
      d4In = 8'hBB;
      applyStimulus();
      checkOutput("ms_w1", 32'(v4Out), 32'h2);
      m4 = 1'b1;
      s4 = 2'd0;
      for (int j = 0; j < 3; j++) begin
         d4In = 8'hC0 + 8'(j);
         applyStimulus();
         checkOutput($sformatf("ms_addr_%0d", j), 32'(v4Out), 32'h1);
      end
      m4 = 1'b0;
      d4In = 8'hDD;
      applyStimulus();
      checkOutput("ms_resume_valid", 32'(v4Out), 32'h4);
      checkOutput("ms_resume_data", 32'(d4Out[23:16]), 32'hDD);
      v4In = 1'b0;

      // Backpressure on two channels
      v2In = 1'b1;
      d2In = 8'h11;
      applyStimulus();
      checkOutput("bp_w0", 32'(v2Out), 32'h1);
      d2In = 8'h22;
      applyStimulus();
      checkOutput("bp_w1", 32'(v2Out), 32'h3);
      d2In = 8'h33;
      #1;
      checkOutput("bp_stall", 32'(r2Out), 32'h0);
      applyStimulus();
      checkOutput("bp_hold", 32'(d2Out), 32'h2211);
      rdy2 = 2'b01;
      #1;
      checkOutput("bp_release", 32'(r2Out), 32'h1);
      applyStimulus();
      checkOutput("bp_replace_valid", 32'(v2Out), 32'h3);
      checkOutput("bp_replace_data", 32'(d2Out), 32'h2233);
      v2In = 1'b0;

      // Addressed mode and saturating drop counter on three channels
      m3 = 1'b1;
      s3 = 2'd2;
      d3In = 8'h5A;
      v3In = 1'b1;
      applyStimulus();
      checkOutput("addr_valid", 32'(v3Out), 32'h4);
      checkOutput("addr_data", 32'(d3Out), 32'h5A0000);
      s3 = 2'd3;
      d3In = 8'h77;
      #1;
      checkOutput("drop_ready", 32'(r3Out), 32'h1);
      applyStimulus();
      checkOutput("drop_first", 32'(drop3), 32'h1);
      for (int i = 0; i < 253; i++) applyStimulus();
      checkOutput("drop_254", 32'(drop3), 32'hFE);
      applyStimulus();
      checkOutput("drop_255", 32'(drop3), 32'hFF);
      for (int i = 0; i < 45; i++) applyStimulus();
      v3In = 1'b0;
      checkOutput("drop_sat", 32'(drop3), 32'hFF);
      checkOutput("drop_valid", 32'(v3Out), 32'h4);
      checkOutput("drop_data", 32'(d3Out), 32'h5A0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
